// File: rtl/l0_scaler_counter.sv
// L0 scaler pulse counter: counts per-channel pulses and stuck indications
// over a fixed gate period, snapshots them at each gate boundary into a
// holding bank, and serves the bank through an addressed read port.
module l0_scaler_counter #(
  parameter int unsigned NCH         = 12,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned GATE_CYCLES = 33000000,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              mclk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic [NCH-1:0]    pulse_i,
  input  logic [NCH-1:0]    stuck_i,
  input  logic              rd_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [CNT_W-1:0]  data_o,
  output logic              valid_o,
  output logic [NCH-1:0]    stuck_flags_o,
  output logic              done_o,
  input  logic              ack_i,
  output logic              overrun_o
);

  localparam int unsigned      TmrW   = $clog2(GATE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [TmrW-1:0]  timer_q, timer_d;
  logic             tick;
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [CNT_W-1:0] cnt_inc[NCH];
  logic [CNT_W-1:0] hold_q [NCH];
  logic [CNT_W-1:0] hold_d [NCH];
  logic [NCH-1:0]   stuck_q, stuck_d;
  logic [NCH-1:0]   flags_q, flags_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] rd_word;

  // Gate timer: advances only while enabled; the last count is the boundary.
  always_comb begin
    tick    = enable_i && (timer_q == TmrW'(GATE_CYCLES - 1));
    timer_d = timer_q;
    if (tick) begin
      timer_d = '0;
    end else if (enable_i) begin
      timer_d = timer_q + TmrW'(1);
    end
  end

  // Live counters saturate; the tick-cycle pulse lands in the snapshot.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_inc[i] = (pulse_i[i] && (cnt_q[i] != CntMax)) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
      cnt_d[i]   = cnt_q[i];
      hold_d[i]  = hold_q[i];
      if (tick) begin
        hold_d[i] = cnt_inc[i];
        cnt_d[i]  = '0;
      end else if (enable_i) begin
        cnt_d[i] = cnt_inc[i];
      end
    end
  end

  // Stuck tracking, snapshot handshake and overrun; a tick beats a same-cycle ack.
  always_comb begin
    stuck_d = stuck_q;
    flags_d = flags_q;
    if (tick) begin
      stuck_d = '0;
      flags_d = stuck_q | stuck_i;
    end else if (enable_i) begin
      stuck_d = stuck_q | stuck_i;
    end

    done_d = done_q;
    if (ack_i) begin
      done_d = 1'b0;
    end
    if (tick) begin
      done_d = 1'b1;
    end

    ovr_d = ovr_q;
    if (ack_i && done_q) begin
      ovr_d = 1'b0;
    end
    if (tick && done_q) begin
      ovr_d = 1'b1;
    end
  end

  // Read port: one-cycle latency from the holding bank; out-of-range reads 0.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (addr_i == ADDR_W'(i)) begin
        rd_word = hold_q[i];
      end
    end
    valid_d = rd_i;
    data_d  = rd_i ? rd_word : data_q;
  end

  // State registers.
  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
      stuck_q <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      timer_q <= timer_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hold_q[i] <= hold_d[i];
      end
      stuck_q <= stuck_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign stuck_flags_o = flags_q;
  assign done_o        = done_q;
  assign overrun_o     = ovr_q;

endmodule
